// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Imported by the interface users and the digit/top modules.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_RUN     = 2'd1,
        TMR_PAUSE   = 2'd2,
        TMR_EXPIRED = 2'd3
    } tmr_state_e;

    localparam logic [3:0] BCD_ZERO = 4'h0;
    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [3:0] BCD_FIVE = 4'h5;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control, load and display bundle of the countdown timer.
// The master drives requests and load digits; the slave (timer) drives the display and status.
interface bcd_countdown_timer_if;

    logic       tick;
    logic       load;
    logic [3:0] ld_min_tens;
    logic [3:0] ld_min_units;
    logic [3:0] ld_sec_tens;
    logic [3:0] ld_sec_units;
    logic       start;
    logic       pause;

    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       expired;
    logic       done;
    logic       load_err;

    modport master (
        output tick, load, ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units, start, pause,
        input  min_tens, min_units, sec_tens, sec_units, running, expired, done, load_err
    );

    modport slave (
        input  tick, load, ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units, start, pause,
        output min_tens, min_units, sec_tens, sec_units, running, expired, done, load_err
    );

endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit: loads, decrements on enable and wraps to wrap_val at zero.
// borrow_out tells the next more-significant digit to step.
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic [3:0] wrap_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = ld_val;
        end else if (en) begin
            digit_d = (digit_q == BCD_ZERO) ? wrap_val : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = en && (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Settable MM:SS countdown timer: control FSM and load validation over four cascaded BCD digits.
// Emits a one-cycle done pulse on reaching 00:00 and holds there until a valid load.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_countdown_timer_if.slave  tmr
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    tmr_state_e state_q, state_d;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;

    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic       su_borrow, st_borrow, mu_borrow, mt_borrow;

    logic ld_valid, loadable, load_ok, dec, start_ok, is_zero, at_one;

    always_comb begin
        ld_valid = (tmr.ld_min_tens <= MT_MAX) && is_bcd(tmr.ld_min_units) &&
                   (tmr.ld_sec_tens <= BCD_FIVE) && is_bcd(tmr.ld_sec_units);
        loadable   = (state_q != TMR_RUN);
        load_ok    = tmr.load && loadable && ld_valid;
        load_err_d = tmr.load && loadable && !ld_valid;
        is_zero    = (mt_q == BCD_ZERO) && (mu_q == BCD_ZERO) &&
                     (st_q == BCD_ZERO) && (su_q == BCD_ZERO);
        at_one     = (mt_q == BCD_ZERO) && (mu_q == BCD_ZERO) &&
                     (st_q == BCD_ZERO) && (su_q == 4'd1);
        // pause outranks a same-cycle tick, so the digits freeze on the pause edge
        dec        = (state_q == TMR_RUN) && tmr.tick && !tmr.pause;
        // any load request (even a rejected one) swallows a same-cycle start
        start_ok   = tmr.start && !tmr.pause && !tmr.load && !is_zero &&
                     ((state_q == TMR_IDLE) || (state_q == TMR_PAUSE));

        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            TMR_IDLE, TMR_PAUSE: begin
                if (start_ok) state_d = TMR_RUN;
            end
            TMR_RUN: begin
                if (tmr.pause) begin
                    state_d = TMR_PAUSE;
                end else if (dec && at_one) begin
                    state_d = TMR_EXPIRED;
                    done_d  = 1'b1;
                end
            end
            TMR_EXPIRED: begin
                if (load_ok) state_d = TMR_IDLE;
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TMR_IDLE;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_down_digit u_sec_units (
        .clk(clk), .rst(rst), .en(dec), .ld(load_ok),
        .ld_val(tmr.ld_sec_units), .wrap_val(BCD_NINE),
        .digit(su_q), .borrow_out(su_borrow)
    );

    bcd_down_digit u_sec_tens (
        .clk(clk), .rst(rst), .en(su_borrow), .ld(load_ok),
        .ld_val(tmr.ld_sec_tens), .wrap_val(BCD_FIVE),
        .digit(st_q), .borrow_out(st_borrow)
    );

    bcd_down_digit u_min_units (
        .clk(clk), .rst(rst), .en(st_borrow), .ld(load_ok),
        .ld_val(tmr.ld_min_units), .wrap_val(BCD_NINE),
        .digit(mu_q), .borrow_out(mu_borrow)
    );

    bcd_down_digit u_min_tens (
        .clk(clk), .rst(rst), .en(mu_borrow), .ld(load_ok),
        .ld_val(tmr.ld_min_tens), .wrap_val(BCD_ZERO),
        .digit(mt_q), .borrow_out(mt_borrow)
    );

    // RUN is never entered at 00:00, so the top digit can never be asked to borrow
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!mt_borrow);
        end
    end

    assign tmr.min_tens  = mt_q;
    assign tmr.min_units = mu_q;
    assign tmr.sec_tens  = st_q;
    assign tmr.sec_units = su_q;
    assign tmr.running   = (state_q == TMR_RUN);
    assign tmr.expired   = (state_q == TMR_EXPIRED);
    assign tmr.done      = done_q;
    assign tmr.load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random traffic,
// compared against a seconds-count reference model.
module tb_bcd_countdown_timer;

    localparam int unsigned TB_MTM = 5;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_state;
    int   m_secs;
    bit   m_done;
    bit   m_lerr;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(.MIN_TENS_MAX(TB_MTM)) dut (
        .clk(clk),
        .rst(rst),
        .tmr(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit ld_ok(input logic [15:0] v);
        return (int'(v[15:12]) <= int'(TB_MTM)) && (v[11:8] <= 4'd9) &&
               (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int bcd_to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_step(input bit tk, input bit ld, input logic [15:0] v,
                              input bit st, input bit ps, input bit r);
        m_done = 0;
        m_lerr = 0;
        if (r) begin
            m_secs  = 0;
            m_state = M_IDLE;
        end else if (ld && m_state != M_RUN) begin
            if (ld_ok(v)) begin
                m_secs = bcd_to_secs(v);
                if (m_state == M_EXP) m_state = M_IDLE;
            end else begin
                m_lerr = 1;
            end
        end else if (m_state == M_RUN) begin
            if (ps) begin
                m_state = M_PAUSE;
            end else if (tk) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_state = M_EXP;
                    m_done  = 1;
                end
            end
        end else if ((m_state == M_IDLE || m_state == M_PAUSE) && st && !ps && m_secs > 0) begin
            m_state = M_RUN;
        end
    endtask

    task automatic cycle(input bit tk, input bit ld, input logic [15:0] v,
                         input bit st, input bit ps, input bit r);
        bus.tick         = tk;
        bus.load         = ld;
        bus.ld_min_tens  = v[15:12];
        bus.ld_min_units = v[11:8];
        bus.ld_sec_tens  = v[7:4];
        bus.ld_sec_units = v[3:0];
        bus.start        = st;
        bus.pause        = ps;
        rst              = r;
        @(posedge clk);
        model_step(tk, ld, v, st, ps, r);
        #1;
        check("digits",   {16'h0, bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units},
              {16'h0, secs_to_bcd(m_secs)});
        check("running",  32'(bus.running),  32'(m_state == M_RUN));
        check("expired",  32'(bus.expired),  32'(m_state == M_EXP));
        check("done",     32'(bus.done),     32'(m_done));
        check("load_err", 32'(bus.load_err), 32'(m_lerr));
    endtask

    task automatic idle1();      cycle(0, 0, 16'h0, 0, 0, 0); endtask
    task automatic tick1();      cycle(1, 0, 16'h0, 0, 0, 0); endtask
    task automatic start1();     cycle(0, 0, 16'h0, 1, 0, 0); endtask
    task automatic load1(input logic [15:0] v); cycle(0, 1, v, 0, 0, 0); endtask

    function automatic logic [15:0] shown();
        return {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
    endfunction

    initial begin
        logic [15:0] v;
        bit tk, ld, st, ps, r;
        int done_cnt;

        bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
        bus.ld_min_tens = 0; bus.ld_min_units = 0; bus.ld_sec_tens = 0; bus.ld_sec_units = 0;
        rst = 1;
        m_state = M_IDLE; m_secs = 0; m_done = 0; m_lerr = 0;

        // reset state
        cycle(1, 1, 16'h1234, 1, 0, 1);
        check("rst_digits", 32'(shown()), 32'h0000);
        check("rst_running", 32'(bus.running), 32'h0);

        // 01:05 counting across the minute boundary
        load1(16'h0105);
        start1();
        for (int i = 0; i < 6; i++) begin
            tick1();
            check("run_flag", 32'(bus.running), 32'h1);
        end
        check("after6", 32'(shown()), 32'h0059);

        // terminal count
        cycle(0, 0, 16'h0, 0, 1, 0);
        load1(16'h0002);
        start1();
        tick1();
        check("at_0001", 32'(shown()), 32'h0001);
        tick1();
        check("term_done", 32'(bus.done), 32'h1);
        check("term_exp", 32'(bus.expired), 32'h1);
        check("term_val", 32'(shown()), 32'h0000);
        done_cnt = 0;
        tick1(); done_cnt += int'(bus.done);
        start1(); done_cnt += int'(bus.done);
        tick1(); done_cnt += int'(bus.done);
        check("done_once", 32'(done_cnt), 32'h0);
        check("exp_hold", 32'(bus.expired), 32'h1);

        // pause beats tick
        load1(16'h1000);
        check("exp_to_idle", 32'(bus.expired), 32'h0);
        start1();
        cycle(1, 0, 16'h0, 0, 1, 0);
        check("paused_val", 32'(shown()), 32'h1000);
        check("paused_run", 32'(bus.running), 32'h0);
        start1();
        tick1();
        check("resume_val", 32'(shown()), 32'h0959);

        // invalid loads and zero start
        cycle(0, 0, 16'h0, 0, 0, 1);
        load1(16'h0060);
        check("lerr_sec", 32'(bus.load_err), 32'h1);
        check("lerr_keep", 32'(shown()), 32'h0000);
        load1(16'h6000);
        check("lerr_mt", 32'(bus.load_err), 32'h1);
        load1(16'h5959);
        check("mt_max_ok", 32'(shown()), 32'h5959);
        load1(16'h0000);
        start1();
        check("zero_start", 32'(bus.running), 32'h0);

        // load ignored in RUN, rst mid-run
        load1(16'h0030);
        start1();
        load1(16'h0500);
        check("run_load_ign", 32'(shown()), 32'h0030);
        check("run_no_lerr", 32'(bus.load_err), 32'h0);
        cycle(1, 0, 16'h0, 0, 0, 1);
        check("midrst", 32'(shown()), 32'h0000);
        check("midrst_done", 32'(bus.done), 32'h0);

        // load beats start from EXPIRED
        load1(16'h0001);
        start1();
        tick1();
        cycle(0, 1, 16'h0010, 1, 0, 0);
        check("exp_ld_val", 32'(shown()), 32'h0010);
        check("exp_ld_run", 32'(bus.running), 32'h0);
        start1();
        check("exp_restart", 32'(bus.running), 32'h1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            tk = ($urandom_range(99) < 40);
            ld = ($urandom_range(99) < 6);
            st = ($urandom_range(99) < 12);
            ps = ($urandom_range(99) < 5);
            r  = ($urandom_range(999) < 5);
            if ($urandom_range(1) == 0) begin
                v = {4'h0, 4'h0, 4'($urandom_range(1)), 4'($urandom_range(9))};
            end else if ($urandom_range(9) == 0) begin
                v = 16'($urandom);
            end else begin
                v = {4'($urandom_range(6)), 4'($urandom_range(9)),
                     4'($urandom_range(6)), 4'($urandom_range(9))};
            end
            cycle(tk, ld, v, st, ps, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Settable MM:SS countdown timer built from cascaded BCD down-counting digits; the count-down counterpart of the clock's up-counting BCD hour/minute chain.
- Shares the clock's 1 Hz tick enable.
- Drives the same 4-bit-per-digit display path as the time-of-day counters.
- Raises a one-cycle done pulse and a level expired flag when 00:00 is reached.

Parameters:
- MIN_TENS_MAX, 9: largest minutes-tens digit accepted on load; must be 1..9.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz enable pulse.
- load  in  1  load request for the four digit inputs below.
- ld_min_tens  in  4  BCD load value, minutes tens.
- ld_min_units  in  4  BCD load value, minutes units.
- ld_sec_tens  in  4  BCD load value, seconds tens.
- ld_sec_units  in  4  BCD load value, seconds units.
- start  in  1  one-cycle start/resume request.
- pause  in  1  one-cycle pause request.
- min_tens  out  4  current minutes tens digit.
- min_units  out  4  current minutes units digit.
- sec_tens  out  4  current seconds tens digit.
- sec_units  out  4  current seconds units digit.
- running  out  1  high while state is RUN.
- expired  out  1  high while state is EXPIRED.
- done  out  1  one-cycle pulse on reaching 00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: rst sampled at the clk edge. All digits 0, state IDLE, running/expired/done/load_err 0. rst overrides every other input, including mid-RUN.
- States and encoding: IDLE, RUN, PAUSE, EXPIRED. Outputs are registered; running and expired are decoded from the state register.
- Load validity: min_tens <= MIN_TENS_MAX, min_units <= 9, sec_tens <= 5, sec_units <= 9.
- Load in IDLE, PAUSE or EXPIRED:
  - Valid: digits updated at the next edge; IDLE stays IDLE, PAUSE stays PAUSE, EXPIRED goes to IDLE.
  - Invalid: digits and state unchanged; load_err = 1 for one cycle.
- Load in RUN: ignored, no load_err.
- Load and start in the same cycle: load wins, start is dropped.
- Start:
  - IDLE or PAUSE with a nonzero value: go to RUN at the next edge. No decrement occurs in the transition cycle even if tick is high.
  - Value 00:00, state RUN, or state EXPIRED: ignored.
- Pause:
  - RUN: go to PAUSE. Pause beats a same-cycle tick, so no decrement.
  - Any other state: ignored.
  - start and pause together in IDLE or PAUSE: no action.
- Decrement: only in RUN with tick = 1; one second per tick. Borrow chain:
  - sec_units 0 -> 9 with borrow; otherwise -1.
  - sec_tens on borrow: 0 -> 5 with borrow; otherwise -1.
  - min_units on borrow: 0 -> 9 with borrow; otherwise -1.
  - min_tens on borrow: -1. It cannot underflow because RUN is never entered at 00:00.
- Terminal count: a tick in RUN at 00:01 loads 00:00 and moves to EXPIRED on the same edge. done = 1 for exactly that following cycle, coincident with the display first showing 00:00.
- EXPIRED: holds 00:00 and ignores tick, start and pause. It is left only by a valid load or by rst.
- tick outside RUN has no effect.
- Digits never hold non-BCD values: load validation plus the wrap rules guarantee it.

Decomposition:
- Shared package (clock_pkg):
  - state encoding constants TMR_IDLE/TMR_RUN/TMR_PAUSE/TMR_EXPIRED (2-bit).
  - BCD constants BCD_ZERO = 4'h0, BCD_NINE = 4'h9, BCD_FIVE = 4'h5.
- Sub-module bcd_down_digit, instantiated 4 times:
  - inputs: clk, rst, en (borrow_in), ld, ld_val, wrap_val.
  - outputs: digit, borrow_out (digit == 0 and en).
  - The FSM and validation stay in the top module.

Test Plan:
- rst, load 01:05, start, 6 ticks -> 01:04, 01:03, 01:02, 01:01, 01:00, 00:59; running = 1 throughout.
- load 00:02, start, 2 ticks -> 00:01, then 00:00; done = 1 for exactly one cycle; expired stays 1; further ticks and start leave 00:00.
- RUN at 10:00; pause and tick in the same cycle -> PAUSE, value stays 10:00; start, tick -> 09:59.
- IDLE, load 00:60 (sec_tens = 6) -> load_err pulse, digits unchanged; load 00:00 then start -> state stays IDLE.
- RUN at 00:30; load 05:00 -> ignored, no load_err; rst asserted mid-run -> 00:00 IDLE next edge; done never pulses.
- EXPIRED, valid load 00:10 together with start -> IDLE at 00:10 (start dropped); next start -> RUN.
